// File: rtl/ddr_rd_burst_align.sv
// Aligns DQS read-buffer rise/fall captures into BL4/BL8 burst words, one per queued READ.
// Define DDR_RD_BURST_ALIGN_STATS_EN to add the BURST_CNT / ERR_CNT statistics outputs.
module ddr_rd_burst_align #(
  parameter int DW        = 8,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic            SCLKB,
  input  logic            reset_prmbdet_clean,
  input  logic            READ,
  input  logic            BURST8,
  input  logic            DATAVALID,
  input  logic            DDRCLKPOL,
  input  logic [DW-1:0]   DQ_RISE,
  input  logic [DW-1:0]   DQ_FALL,
  output logic [8*DW-1:0] RD_DATA,
  output logic            RD_VALID,
  output logic            RD_BL8,
  output logic            RD_ERR,
  output logic            CMD_FULL,
  output logic            CMD_OVF
`ifdef DDR_RD_BURST_ALIGN_STATS_EN
  ,
  output logic [15:0]     BURST_CNT,
  output logic [7:0]      ERR_CNT
`endif
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COLLECT, S_ALIGN1} state_t;

  state_t               state;
  logic                 cmd_mem [CMD_DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [AW:0]          cmd_cnt;
  logic                 push, pop, done, fail;
  logic                 bl, pol;
  logic [TW-1:0]        timer;
  logic [3:0]           beat_cnt, need;
  logic [7:0][DW-1:0]   beats, beats_nxt;
  logic [DW-1:0]        beat_a, beat_b;
  logic                 wr_a, wr_b;
  logic                 more_cmds, head_nxt;

  assign CMD_FULL  = (cmd_cnt == (AW+1)'(CMD_DEPTH));
  assign pop       = done | fail;
  assign push      = READ & (~CMD_FULL | pop);
  assign need      = bl ? 4'd8 : 4'd4;
  // Head after this cycle's pop: the next stored entry, or the READ arriving right now.
  assign more_cmds = (cmd_cnt > (AW+1)'(1)) | push;
  assign head_nxt  = (cmd_cnt > (AW+1)'(1)) ? cmd_mem[AW'(rd_ptr + 1'b1)] : BURST8;

  always_ff @(posedge SCLKB) begin
    if (push) cmd_mem[wr_ptr] <= BURST8;
  end

  always_ff @(posedge SCLKB or posedge reset_prmbdet_clean) begin
    if (reset_prmbdet_clean) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cmd_cnt <= '0;
      CMD_OVF <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
        2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
        default: cmd_cnt <= cmd_cnt;
      endcase
      if (READ && CMD_FULL && !pop) CMD_OVF <= 1'b1;
    end
  end

  // With pol=1 the first rise beat is stale, so beat0 is that cycle's fall capture.
  always_comb begin
    beats_nxt = beats;
    beat_a    = DQ_RISE;
    beat_b    = DQ_FALL;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    case (state)
      S_WAIT: begin
        if (DATAVALID) begin
          wr_a = 1'b1;
          if (pol) beat_a = DQ_FALL;
          else     wr_b = 1'b1;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          fail = 1'b1;
        end
      end
      S_COLLECT: begin
        if (DATAVALID) begin
          wr_a = 1'b1;
          wr_b = 1'b1;
          if (!pol && (beat_cnt + 4'd2 == need)) done = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      S_ALIGN1: begin
        if (DATAVALID) begin
          wr_a = 1'b1;
          done = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < 8; i++) begin
      if (wr_a && beat_cnt == 4'(i))         beats_nxt[i] = beat_a;
      if (wr_b && beat_cnt + 4'd1 == 4'(i))  beats_nxt[i] = beat_b;
    end
  end

  always_ff @(posedge SCLKB or posedge reset_prmbdet_clean) begin
    if (reset_prmbdet_clean) begin
      state    <= S_IDLE;
      bl       <= 1'b0;
      pol      <= 1'b0;
      timer    <= '0;
      beat_cnt <= '0;
      beats    <= '0;
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
      RD_BL8   <= 1'b0;
      RD_ERR   <= 1'b0;
    end else begin
      RD_VALID <= 1'b0;
      RD_ERR   <= fail;
      beats    <= beats_nxt;
      case (state)
        S_IDLE: begin
          if (cmd_cnt != '0) begin
            state    <= S_WAIT;
            bl       <= cmd_mem[rd_ptr];
            pol      <= DDRCLKPOL;
            timer    <= '0;
            beat_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (DATAVALID) begin
            state    <= S_COLLECT;
            beat_cnt <= pol ? 4'd1 : 4'd2;
          end else if (fail) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COLLECT: begin
          if (fail) begin
            state <= S_IDLE;
          end else begin
            beat_cnt <= beat_cnt + 4'd2;
            if (pol && (beat_cnt + 4'd2 == need - 4'd1)) state <= S_ALIGN1;
          end
        end
        S_ALIGN1: begin
          if (fail) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (done) begin
        RD_VALID <= 1'b1;
        RD_BL8   <= bl;
        RD_DATA  <= bl ? beats_nxt : {{(4*DW){1'b0}}, beats_nxt[3:0]};
        if (more_cmds) begin
          state    <= S_WAIT;
          bl       <= head_nxt;
          pol      <= DDRCLKPOL;
          timer    <= '0;
          beat_cnt <= '0;
        end else begin
          state <= S_IDLE;
        end
      end
    end
  end

`ifdef DDR_RD_BURST_ALIGN_STATS_EN
  always_ff @(posedge SCLKB or posedge reset_prmbdet_clean) begin
    if (reset_prmbdet_clean) begin
      BURST_CNT <= '0;
      ERR_CNT   <= '0;
    end else begin
      if (RD_VALID)                  BURST_CNT <= BURST_CNT + 1'b1;
      if (RD_ERR && ERR_CNT != 8'hFF) ERR_CNT  <= ERR_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_rd_burst_align.sv
// Scoreboard bench for ddr_rd_burst_align: stimulus queues expected bursts/errors, a negedge monitor checks them.
module tb_ddr_rd_burst_align;

  typedef struct {
    bit          is_err;
    logic [63:0] data;
    bit          bl8;
    int          cyc;
  } exp_t;

  logic        SCLKB = 1'b0;
  logic        reset_prmbdet_clean;
  logic        READ, BURST8, DATAVALID, DDRCLKPOL;
  logic [7:0]  DQ_RISE, DQ_FALL;
  logic [63:0] RD_DATA;
  logic        RD_VALID, RD_BL8, RD_ERR, CMD_FULL, CMD_OVF;
`ifdef DDR_RD_BURST_ALIGN_STATS_EN
  logic [15:0] BURST_CNT;
  logic [7:0]  ERR_CNT;
`endif

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ddr_rd_burst_align #(.DW(8), .CMD_DEPTH(4), .TIMEOUT(32)) dut (
    .SCLKB(SCLKB), .reset_prmbdet_clean(reset_prmbdet_clean),
    .READ(READ), .BURST8(BURST8), .DATAVALID(DATAVALID), .DDRCLKPOL(DDRCLKPOL),
    .DQ_RISE(DQ_RISE), .DQ_FALL(DQ_FALL),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_BL8(RD_BL8), .RD_ERR(RD_ERR),
    .CMD_FULL(CMD_FULL), .CMD_OVF(CMD_OVF)
`ifdef DDR_RD_BURST_ALIGN_STATS_EN
    , .BURST_CNT(BURST_CNT), .ERR_CNT(ERR_CNT)
`endif
  );

  always #5 SCLKB = ~SCLKB;
  always @(posedge SCLKB) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge SCLKB);
    #1;
  endtask

  task automatic issue_read(input bit b8, input bit p);
    READ = 1'b1; BURST8 = b8; DDRCLKPOL = p;
    tick();
    READ = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [7:0] r, input logic [7:0] f);
    DATAVALID = 1'b1; DQ_RISE = r; DQ_FALL = f;
    tick();
  endtask

  task automatic quiet(input int n);
    DATAVALID = 1'b0;
    repeat (n) tick();
  endtask

  always @(negedge SCLKB) begin
    if (!reset_prmbdet_clean && (RD_VALID || RD_ERR)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output valid=%0b err=%0b data=%0h", RD_VALID, RD_ERR, RD_DATA);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("kind_err", 64'(RD_ERR), 64'(e.is_err));
        check("kind_valid", 64'(RD_VALID), 64'(!e.is_err));
        if (!e.is_err) begin
          check("rd_data", RD_DATA, e.data);
          check("rd_bl8", 64'(RD_BL8), 64'(e.bl8));
        end
        if (e.cyc >= 0) check("event_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_data"}, RD_DATA, 64'h0);
    check({tag, "_rd_valid"}, 64'(RD_VALID), 64'h0);
    check({tag, "_rd_bl8"}, 64'(RD_BL8), 64'h0);
    check({tag, "_rd_err"}, 64'(RD_ERR), 64'h0);
    check({tag, "_cmd_full"}, 64'(CMD_FULL), 64'h0);
    check({tag, "_cmd_ovf"}, 64'(CMD_OVF), 64'h0);
  endtask

  logic [63:0] b2b_exp [4] = '{64'h04030201, 64'h08070605, 64'h0C0B0A09, 64'h100F0E0D};

  initial begin
    int c;
    reset_prmbdet_clean = 1'b1;
    READ = 0; BURST8 = 0; DATAVALID = 0; DDRCLKPOL = 0; DQ_RISE = 0; DQ_FALL = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_prmbdet_clean = 1'b0;
    tick();

    // BL4, pol=0
    issue_read(1'b0, 1'b0);
    q.push_back('{1'b0, 64'h0000_0000_4433_2211, 1'b0, -1});
    beat(8'h11, 8'h22);
    beat(8'h33, 8'h44);
    quiet(3);

    // BL8, pol=1; polarity flips mid-burst and must be ignored
    issue_read(1'b1, 1'b1);
    q.push_back('{1'b0, 64'h0807_0605_0403_0201, 1'b1, -1});
    beat(8'hAA, 8'h01);
    DDRCLKPOL = 1'b0;
    beat(8'h02, 8'h03);
    beat(8'h04, 8'h05);
    beat(8'h06, 8'h07);
    beat(8'h08, 8'hBB);
    quiet(3);

    // timeout: WAIT entered on the second issue_read edge
    issue_read(1'b0, 1'b0);
    c = cyc;
    q.push_back('{1'b1, 64'h0, 1'b0, c + 32});
    quiet(40);

    // five back-to-back READs into a 4-deep queue
    READ = 1'b1; BURST8 = 1'b0; DDRCLKPOL = 1'b0;
    repeat (4) tick();
    check("full_after_4", 64'(CMD_FULL), 64'h1);
    check("ovf_after_4", 64'(CMD_OVF), 64'h0);
    tick();
    check("ovf_after_5", 64'(CMD_OVF), 64'h1);
    check("full_after_5", 64'(CMD_FULL), 64'h1);
    READ = 1'b0;
    c = cyc;
    for (int k = 0; k < 4; k++) q.push_back('{1'b0, b2b_exp[k], 1'b0, c + 2 + 2*k});
    for (int i = 0; i < 8; i++) beat(8'(2*i + 1), 8'(2*i + 2));
    quiet(3);
    check("full_drained", 64'(CMD_FULL), 64'h0);
    check("ovf_sticky", 64'(CMD_OVF), 64'h1);

    // BL8 aborted after two cycles, then a queued BL4
    READ = 1'b1; BURST8 = 1'b1;
    tick();
    BURST8 = 1'b0;
    tick();
    READ = 1'b0;
    beat(8'hA1, 8'hA2);
    beat(8'hA3, 8'hA4);
    c = cyc;
    q.push_back('{1'b1, 64'h0, 1'b0, c + 1});
    q.push_back('{1'b0, 64'h0000_0000_8877_6655, 1'b0, -1});
    quiet(4);
    beat(8'h55, 8'h66);
    beat(8'h77, 8'h88);
    quiet(3);

`ifdef DDR_RD_BURST_ALIGN_STATS_EN
    check("burst_cnt", 64'(BURST_CNT), 64'd7);
    check("err_cnt", 64'(ERR_CNT), 64'd2);
`endif

    // reset in the middle of COLLECT
    issue_read(1'b1, 1'b0);
    beat(8'h12, 8'h34);
    beat(8'h56, 8'h78);
    reset_prmbdet_clean = 1'b1;
    #1;
    check_idle_outputs("midreset");
`ifdef DDR_RD_BURST_ALIGN_STATS_EN
    check("burst_cnt_reset", 64'(BURST_CNT), 64'd0);
`endif
    DATAVALID = 1'b0;
    tick();
    reset_prmbdet_clean = 1'b0;
    tick();
    issue_read(1'b0, 1'b0);
    q.push_back('{1'b0, 64'h0000_0000_CCBB_AA99, 1'b0, -1});
    beat(8'h99, 8'hAA);
    beat(8'hBB, 8'hCC);
    quiet(5);

    check("pending_expectations", 64'(q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_rd_burst_align.md
Name: ddr_rd_burst_align

Overview:
- Downstream of the DQS read buffer, in the SCLKB domain.
- Consumes the per-cycle rise/fall DQ capture pair, DATAVALID and DDRCLKPOL.
- Assembles complete BL4/BL8 read bursts, correcting beat order when DDRCLKPOL=1.
- Tracks outstanding READ commands in a small queue and emits one aligned burst word per command, with timeout and abort detection.

Parameters:
- DW, 8, DQ lane width per beat.
- CMD_DEPTH, 4, outstanding-read queue depth (power of 2, ≥2).
- TIMEOUT, 32, SCLKB cycles allowed from queue-head becoming active to first DATAVALID.

Ports:
- SCLKB  in  1  clock.
- reset_prmbdet_clean  in  1  reset.
- READ  in  1  one-cycle read command strobe.
- BURST8  in  1  burst length for this READ: 0=BL4, 1=BL8; sampled with READ.
- DATAVALID  in  1  DQ_RISE/DQ_FALL carry valid capture this cycle.
- DDRCLKPOL  in  1  capture polarity from DQS buffer.
- DQ_RISE  in  DW  beat captured on DQS rising edge.
- DQ_FALL  in  DW  beat captured on DQS falling edge.
- RD_DATA  out  8*DW  assembled burst, beat0 in [DW-1:0]; BL4 upper 4 beats zero.
- RD_VALID  out  1  one-cycle pulse, RD_DATA valid.
- RD_BL8  out  1  burst length of RD_DATA.
- RD_ERR  out  1  one-cycle pulse: timeout or mid-burst abort.
- CMD_FULL  out  1  command queue full.
- CMD_OVF  out  1  sticky: READ dropped while full.

Behaviour:
- Interface: reset reset_prmbdet_clean, asynchronous, active-high; clock SCLKB.
- Reset values: all outputs 0; queue empty; FSM IDLE; RD_DATA all zero.
- Command queue:
  - FIFO of BURST8 bits; READ pushes.
  - Push while CMD_FULL → READ dropped, CMD_OVF set (cleared only by reset).
  - Push and pop in the same cycle while full → allowed; the pop frees the slot.
- FSM states IDLE, WAIT, COLLECT, ALIGN1:
  - IDLE: queue non-empty → WAIT; latch head BL, clear timer, latch DDRCLKPOL as pol.
  - WAIT: timer increments each cycle.
    - DATAVALID=1 → COLLECT, store beats (see alignment).
    - Timer reaches TIMEOUT-1 without DATAVALID → RD_ERR pulse, pop head, IDLE.
  - COLLECT: each DATAVALID cycle appends 2 beats. DATAVALID=0 before the burst completes → abort: RD_ERR pulse, discard partial, pop head, IDLE.
  - ALIGN1 (pol=1 only): one extra cycle to consume the trailing rise beat. DATAVALID must be 1; otherwise abort as above.
- Alignment:
  - pol=0: beats are rise,fall per cycle.
  - pol=1: a cycle's DQ_FALL pairs with the next cycle's DQ_RISE. The first cycle's DQ_RISE is discarded; one extra DATAVALID cycle is required.
  - pol is held for the whole burst; DDRCLKPOL changes mid-burst are ignored.
- Beat counts:
  - BL4 needs 2 cycles (pol=0) or 3 (pol=1).
  - BL8 needs 4 or 5.
- Completion:
  - RD_VALID=1 with RD_DATA and RD_BL8 one cycle after the last beat is captured.
  - Head pops in that cycle; FSM → IDLE, or directly → WAIT if the queue is still non-empty after the pop (no bubble).
- RD_DATA holds its value until the next RD_VALID.
- DATAVALID in IDLE is ignored (stray preamble).

Optional Feature:
- Macro DDR_RD_BURST_ALIGN_STATS_EN.
- When defined, adds output ports BURST_CNT[15:0] and ERR_CNT[7:0].
  - BURST_CNT counts RD_VALID pulses, wraps at 0xFFFF.
  - ERR_CNT counts RD_ERR pulses, saturates at 0xFF.
  - Both reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, READ BURST8=0, pol=0, DATAVALID 2 cycles with rise/fall = 0x11/0x22, 0x33/0x44 → RD_VALID once, RD_DATA[31:0]=0x44332211, upper 32 bits 0, RD_BL8=0.
- pol=1, BL8, 5 DATAVALID cycles with rise/fall = (0xAA,0x01),(0x02,0x03),(0x04,0x05),(0x06,0x07),(0x08,0xBB) → RD_DATA=0x0807060504030201, 0xAA and 0xBB unused.
- READ, DATAVALID never asserted → RD_ERR pulse exactly TIMEOUT=32 cycles after WAIT entry; queue empty; RD_VALID never asserted.
- 5 READs back-to-back with CMD_DEPTH=4 → CMD_FULL after the 4th, CMD_OVF=1; 4 bursts served with no idle cycle between them.
- BL8 burst with DATAVALID dropped after 2 cycles → RD_ERR pulse; next queued BL4 burst completes correctly.
- Assert reset_prmbdet_clean mid-COLLECT → all outputs 0 immediately; after release, a new BL4 read completes normally.
